// File: rtl/irq_controller.sv
// irq_controller: prioritised interrupt controller with a small register window.
//
// Each source passes a 2-flop synchroniser and a history flop. Edge-mode sources
// latch a pending bit on a rising edge. Level-mode sources report the
// synchronised line directly. The lowest-index pending and enabled source is
// presented as interrupt_vector (index + 1, 0 = none). It is held until the CPU
// acknowledges it, or until the source goes away.
//
// Ports:
//   clk, reset_n        system clock, asynchronous active-low reset
//   irq_src             raw interrupt lines (asynchronous, active-high)
//   bus_sel             register window select
//   bus_address         byte offset; [4:3] pick PENDING/ENABLE/MODE/CLAIM
//   bus_write_enable    one-cycle write strobe
//   bus_read_enable     one-cycle read strobe
//   bus_write_data      write data (bits above NUM_SRC ignored)
//   bus_read_data       registered read data, valid the cycle after the strobe
//   interrupt_vector    presented vector
//   interrupt_ack       CPU acknowledge of the presented vector
module irq_controller #(
    parameter int unsigned         NUM_SRC      = 4,
    parameter int unsigned         VEC_W        = 4,
    parameter logic [NUM_SRC-1:0]  EDGE_DEFAULT = '1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               bus_sel,
    input  logic [4:0]         bus_address,
    input  logic               bus_write_enable,
    input  logic               bus_read_enable,
    input  logic [63:0]        bus_write_data,
    output logic [63:0]        bus_read_data,
    output logic [VEC_W-1:0]   interrupt_vector,
    input  logic               interrupt_ack
);

    typedef enum logic {StIdle, StPresent} state_e;

    localparam logic [1:0] RegPending = 2'd0;
    localparam logic [1:0] RegEnable  = 2'd1;
    localparam logic [1:0] RegMode    = 2'd2;
    localparam logic [1:0] RegClaim   = 2'd3;

    state_e               state_q, state_d;
    logic [NUM_SRC-1:0]   sync1_q, sync2_q, hist_q;
    logic [NUM_SRC-1:0]   pending_q, pending_d;
    logic [NUM_SRC-1:0]   enable_q, enable_d;
    logic [NUM_SRC-1:0]   mode_q, mode_d;
    logic [VEC_W-1:0]     vec_q, vec_d;
    logic [63:0]          rdata_q, rdata_d;

    logic [NUM_SRC-1:0]   pend_eff, active, rise, w1c, ack_clr, pres_mask;
    logic [VEC_W-1:0]     cand_vec;
    logic                 cand_valid, pres_live;
    logic                 wr_en, rd_en;
    logic [1:0]           reg_sel;
    logic                 unused_bus;

    assign wr_en   = bus_sel & bus_write_enable;
    assign rd_en   = bus_sel & bus_read_enable;
    assign reg_sel = bus_address[4:3];

    // Byte-lane bits and data bits beyond the source count carry no meaning.
    assign unused_bus = ^{bus_address[2:0], bus_write_data[63:NUM_SRC]};

    // Level-mode sources bypass the latch: the synchronised line is the pending bit.
    assign pend_eff = (mode_q & pending_q) | (~mode_q & sync2_q);
    assign active   = pend_eff & enable_q;
    assign rise     = sync2_q & ~hist_q;

    // Lowest index wins: scanning downward lets lower indices overwrite.
    always_comb begin
        cand_valid = 1'b0;
        cand_vec   = '0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (active[i]) begin
                cand_valid = 1'b1;
                cand_vec   = VEC_W'(i + 1);
            end
        end
    end

    // One-hot of the source behind the presented vector.
    always_comb begin
        pres_mask = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            pres_mask[i] = (vec_q == VEC_W'(i + 1));
        end
    end

    assign pres_live = |(pres_mask & active);

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        ack_clr = '0;
        unique case (state_q)
            StIdle: begin
                if (cand_valid) begin
                    vec_d   = cand_vec;
                    state_d = StPresent;
                end
            end
            StPresent: begin
                if (interrupt_ack) begin
                    ack_clr = pres_mask & mode_q;
                    vec_d   = '0;
                    state_d = StIdle;
                end else if (!pres_live) begin
                    vec_d   = '0;
                    state_d = StIdle;
                end
            end
            default: begin
                vec_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        w1c      = '0;
        enable_d = enable_q;
        mode_d   = mode_q;
        if (wr_en) begin
            unique case (reg_sel)
                RegPending: w1c      = bus_write_data[NUM_SRC-1:0];
                RegEnable:  enable_d = bus_write_data[NUM_SRC-1:0];
                RegMode:    mode_d   = bus_write_data[NUM_SRC-1:0];
                RegClaim:   ;
            endcase
        end
        // A new edge wins over any clear landing on the same cycle.
        // Level-mode sources keep their latch cleared.
        pending_d = mode_q & (rise | (pending_q & ~(w1c | ack_clr)));
    end

    // Reads sample the registers before any same-cycle write lands.
    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) begin
            rdata_d = '0;
            unique case (reg_sel)
                RegPending: rdata_d[NUM_SRC-1:0] = pend_eff;
                RegEnable:  rdata_d[NUM_SRC-1:0] = enable_q;
                RegMode:    rdata_d[NUM_SRC-1:0] = mode_q;
                RegClaim:   rdata_d[VEC_W-1:0]   = vec_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            hist_q    <= '0;
            pending_q <= '0;
            enable_q  <= '0;
            mode_q    <= EDGE_DEFAULT;
            state_q   <= StIdle;
            vec_q     <= '0;
            rdata_q   <= '0;
        end else begin
            sync1_q   <= irq_src;
            sync2_q   <= sync1_q;
            hist_q    <= sync2_q;
            pending_q <= pending_d;
            enable_q  <= enable_d;
            mode_q    <= mode_d;
            state_q   <= state_d;
            vec_q     <= vec_d;
            rdata_q   <= rdata_d;
        end
    end

    assign interrupt_vector = vec_q;
    assign bus_read_data    = rdata_q;

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed scenarios followed by random
// traffic. A cycle-level reference model queues the expected vector and read
// data, and a monitor on the falling edge pops and compares them.
module tb_irq_controller;
    localparam int N  = 4;
    localparam int VW = 4;
    localparam logic [N-1:0] EDGE_DEF = 4'hF;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [N-1:0]  irq_src = '0;
    logic          bus_sel = 1'b0;
    logic [4:0]    bus_address = '0;
    logic          bus_write_enable = 1'b0;
    logic          bus_read_enable = 1'b0;
    logic [63:0]   bus_write_data = '0;
    logic [63:0]   bus_read_data;
    logic [VW-1:0] interrupt_vector;
    logic          interrupt_ack = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    irq_controller #(
        .NUM_SRC      (N),
        .VEC_W        (VW),
        .EDGE_DEFAULT (EDGE_DEF)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .irq_src          (irq_src),
        .bus_sel          (bus_sel),
        .bus_address      (bus_address),
        .bus_write_enable (bus_write_enable),
        .bus_read_enable  (bus_read_enable),
        .bus_write_data   (bus_write_data),
        .bus_read_data    (bus_read_data),
        .interrupt_vector (interrupt_vector),
        .interrupt_ack    (interrupt_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [N-1:0] m_pend, m_en, m_mode;
    int           m_vec;
    logic [N-1:0] smp[$];   // raw samples per edge, newest first
    int           vq[$];
    logic [63:0]  rq[$];

    task automatic model_reset();
        m_pend = '0;
        m_en   = '0;
        m_mode = EDGE_DEF;
        m_vec  = 0;
        smp.delete();
        repeat (3) smp.push_back('0);
        vq.delete();
        rq.delete();
    endtask

    task automatic model_step();
        logic [N-1:0] synced, older, eff, rise, w1c, ackclr;
        logic [63:0]  rexp;
        int           nv;
        bit           found;
        // The line seen by the logic lags the pin by two edges.
        synced = smp[1];
        older  = smp[2];
        eff    = (m_mode & m_pend) | (~m_mode & synced);
        if (bus_sel && bus_read_enable) begin
            rexp = '0;
            case (bus_address[4:3])
                2'd0:    rexp[N-1:0] = eff;
                2'd1:    rexp[N-1:0] = m_en;
                2'd2:    rexp[N-1:0] = m_mode;
                default: rexp = 64'(m_vec);
            endcase
            rq.push_back(rexp);
        end
        nv     = m_vec;
        ackclr = '0;
        if (m_vec == 0) begin
            found = 0;
            for (int i = 0; i < N; i++) begin
                if (!found && eff[i] && m_en[i]) begin
                    found = 1;
                    nv    = i + 1;
                end
            end
        end else if (interrupt_ack) begin
            nv = 0;
            ackclr[m_vec-1] = 1'b1;
        end else if (!(eff[m_vec-1] && m_en[m_vec-1])) begin
            nv = 0;
        end
        w1c = '0;
        if (bus_sel && bus_write_enable && bus_address[4:3] == 2'd0) w1c = bus_write_data[N-1:0];
        rise   = synced & ~older;
        m_pend = m_mode & (rise | (m_pend & ~(w1c | ackclr)));
        if (bus_sel && bus_write_enable && bus_address[4:3] == 2'd1) m_en = bus_write_data[N-1:0];
        if (bus_sel && bus_write_enable && bus_address[4:3] == 2'd2) m_mode = bus_write_data[N-1:0];
        smp.push_front(irq_src);
        void'(smp.pop_back());
        m_vec = nv;
        vq.push_back(nv);
    endtask

    initial model_reset();
    always @(negedge reset_n) model_reset();
    always @(posedge clk) if (reset_n) model_step();

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        int          ev;
        logic [63:0] er;
        if (reset_n) begin
            if (vq.size() > 0) begin
                ev = vq.pop_front();
                check("vector", 64'(interrupt_vector), 64'(ev));
            end
            if (rq.size() > 0) begin
                er = rq.pop_front();
                check("read_data", bus_read_data, er);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic bus_wr(input logic [4:0] a, input logic [63:0] d);
        bus_sel = 1'b1; bus_write_enable = 1'b1; bus_address = a; bus_write_data = d;
        tick();
        bus_sel = 1'b0; bus_write_enable = 1'b0;
    endtask

    task automatic bus_rd(input logic [4:0] a);
        bus_sel = 1'b1; bus_read_enable = 1'b1; bus_address = a;
        tick();
        bus_sel = 1'b0; bus_read_enable = 1'b0;
    endtask

    task automatic bus_rw(input logic [4:0] a, input logic [63:0] d);
        bus_sel = 1'b1; bus_read_enable = 1'b1; bus_write_enable = 1'b1;
        bus_address = a; bus_write_data = d;
        tick();
        bus_sel = 1'b0; bus_read_enable = 1'b0; bus_write_enable = 1'b0;
    endtask

    task automatic ack();
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
    endtask

    task automatic wait_vec(input int budget);
        int k = 0;
        while (interrupt_vector == '0 && k < budget) begin
            tick();
            k++;
        end
        n_cmp++;
        if (interrupt_vector == '0) begin
            n_bad++;
            $display("FAIL wait_vec: vector 0 after %0d cycles, required nonzero", budget);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check("reset_vector", 64'(interrupt_vector), 64'd0);
        check("reset_rdata", bus_read_data, 64'd0);
        tick();
        reset_n = 1'b1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int idx;
        do_reset();

        // Single edge source, enable, ack clears pending.
        bus_wr(5'h08, 64'h1);
        irq_src[0] = 1'b1; tick(); tick(); irq_src[0] = 1'b0;
        wait_vec(10);
        bus_rd(5'h00);
        ack(); tick();
        bus_rd(5'h00);
        repeat (3) tick();

        // No preemption by a higher-priority arrival.
        bus_wr(5'h08, 64'hF);
        irq_src[2] = 1'b1;
        wait_vec(10);
        irq_src[0] = 1'b1;
        repeat (6) tick();
        ack(); repeat (2) tick();
        ack(); irq_src = '0;
        repeat (4) tick();

        // Level mode: re-presents after ack, drops when the line drops.
        bus_wr(5'h10, 64'h0);
        irq_src[1] = 1'b1;
        wait_vec(10);
        ack(); repeat (3) tick();
        irq_src[1] = 1'b0;
        repeat (5) tick();
        bus_wr(5'h10, 64'hF);
        tick();

        // Pending but disabled, then enabled, then W1C.
        bus_wr(5'h08, 64'h0);
        irq_src[3] = 1'b1; tick(); tick(); irq_src[3] = 1'b0;
        repeat (4) tick();
        bus_rd(5'h00);
        bus_wr(5'h08, 64'h8);
        repeat (3) tick();
        bus_wr(5'h00, 64'h8);
        repeat (3) tick();
        bus_rd(5'h00);

        // CLAIM reads, ignored low address bits, read-before-write.
        bus_wr(5'h08, 64'hF);
        irq_src[1] = 1'b1; tick(); tick(); irq_src[1] = 1'b0;
        wait_vec(10);
        bus_rd(5'h18);
        bus_rd(5'h1F);
        bus_rw(5'h08, 64'h5);
        bus_rd(5'h08);
        ack(); tick();
        bus_wr(5'h08, 64'hF);

        // Reset mid-PRESENT with a source held high through release.
        irq_src[2] = 1'b1;
        wait_vec(10);
        do_reset();
        bus_rd(5'h08);
        bus_rd(5'h10);
        bus_wr(5'h08, 64'h4);
        wait_vec(10);
        bus_rd(5'h00);
        ack(); irq_src = '0;
        repeat (3) tick();

        // Random traffic.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 5) == 0) begin
                idx = $urandom_range(0, N - 1);
                irq_src[idx] = ~irq_src[idx];
            end
            bus_sel          = ($urandom_range(0, 3) != 0);
            bus_address      = 5'($urandom);
            bus_write_enable = ($urandom_range(0, 5) == 0);
            bus_read_enable  = ($urandom_range(0, 3) == 0);
            bus_write_data   = {$urandom, $urandom};
            interrupt_ack    = ($urandom_range(0, 3) == 0);
            if (c % 500 == 499) do_reset();
            else tick();
        end
        bus_sel = 1'b0; bus_write_enable = 1'b0; bus_read_enable = 1'b0; interrupt_ack = 1'b0;
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
